// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, sequencer states and the stereo frame type for the I2S feeder.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int BITS_PER_WORD = 16;
  localparam int EDGE_W = $clog2(BITS_PER_WORD);
  typedef enum logic [1:0] {FLUSH, IDLE, RUN, STOP} seq_state_t;
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_frame_t;
  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/i2s_frame_sequencer_if.sv
// i2s_frame_sequencer_if: mixer-side frame handshake plus the word/clock outputs toward the transmitter.
interface i2s_frame_sequencer_if;
  import audio_pkg::*;
  logic enable;
  logic [SAMPLE_W-1:0] sampleLeft;
  logic [SAMPLE_W-1:0] sampleRight;
  logic sampleValid;
  logic sampleReady;
  logic bitclk;
  logic lrclk;
  logic [SAMPLE_W-1:0] sampleOut;
  logic underrun;
  logic [7:0] underrunCount;
  logic busy;
  modport master (
    output enable, sampleLeft, sampleRight, sampleValid,
    input sampleReady, bitclk, lrclk, sampleOut, underrun, underrunCount, busy
  );
  modport slave (
    input enable, sampleLeft, sampleRight, sampleValid,
    output sampleReady, bitclk, lrclk, sampleOut, underrun, underrunCount, busy
  );
endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous show-ahead FIFO of stereo frames; pointers carry a wrap bit for full/empty.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  input logic push,
  input stereo_frame_t din,
  input logic pop,
  output stereo_frame_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  stereo_frame_t mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign full = wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]};
  assign empty = wrPtr == rdPtr;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign dout = mem[rdPtr[AW-1:0]];
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer: buffers stereo frames and paces bitclk, lrclk and 16-bit words for an I2S serialiser.
module i2s_frame_sequencer
  import audio_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  i2s_frame_sequencer_if.slave bus
);
  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  seq_state_t state, stateNext;
  logic [DIV_W-1:0] divCnt;
  logic [EDGE_W-1:0] edgeCount;
  logic [SAMPLE_W-1:0] sampleOut, rightWord;
  logic [7:0] underrunCount;
  logic bitclk, lrclk, underrun, live;
  stereo_frame_t head, frame;
  logic full, empty;
  logic flushDone, clkRun, toggle, loadFall, startLoad, load, starve;
  sample_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk),
    .reset(reset),
    .push(bus.sampleValid),
    .din('{left: bus.sampleLeft, right: bus.sampleRight}),
    .pop(load && lrclk),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign flushDone = edgeCount == '0 && !bitclk;
  assign clkRun = state == RUN || state == STOP || (state == FLUSH && !flushDone);
  // live gates the divider so edgeCount, which has no reset, never counts while reset holds bitclk low.
  assign toggle = live && clkRun && divCnt == DIV_LAST;
  assign loadFall = toggle && bitclk && edgeCount == '0 && (state == RUN || state == STOP);
  assign startLoad = state == IDLE && bus.enable && !empty;
  assign load = startLoad || (loadFall && !(state == STOP && lrclk && !bus.enable));
  assign starve = load && lrclk && empty;
  assign frame = empty ? '0 : head;
  always_comb begin
    stateNext = state;
    unique case (state)
      FLUSH: stateNext = flushDone ? IDLE : FLUSH;
      IDLE: stateNext = startLoad ? RUN : IDLE;
      RUN: stateNext = bus.enable ? RUN : STOP;
      STOP: stateNext = bus.enable ? RUN : (loadFall && lrclk) ? IDLE : STOP;
      default: stateNext = FLUSH;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FLUSH;
    else state <= stateNext;
  always_ff @(posedge clk)
    if (toggle && !bitclk) edgeCount <= edgeCount + 1'b1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live <= 1'b0;
      divCnt <= '0;
      bitclk <= 1'b0;
      lrclk <= 1'b1;
      sampleOut <= '0;
      rightWord <= '0;
      underrun <= 1'b0;
      underrunCount <= '0;
    end else begin
      live <= 1'b1;
      divCnt <= (!clkRun || toggle) ? '0 : divCnt + 1'b1;
      bitclk <= clkRun && (bitclk ^ toggle);
      underrun <= starve;
      if (starve) underrunCount <= satInc(underrunCount);
      if (state == FLUSH) sampleOut <= '0;
      else if (load) begin
        sampleOut <= lrclk ? frame.left : rightWord;
        if (lrclk) rightWord <= frame.right;
        lrclk <= !lrclk;
      end
    end
  end
  assign bus.sampleReady = !full;
  assign bus.bitclk = bitclk;
  assign bus.lrclk = lrclk;
  assign bus.sampleOut = sampleOut;
  assign bus.underrun = underrun;
  assign bus.underrunCount = underrunCount;
  assign bus.busy = state != IDLE;
endmodule
